// File: rtl/nanov_periph_hub.sv
// nanoV peripheral hub: GPIO bank, UART TX FIFO with drain FSM, RX pop, status.
// Define NANOV_PERIPH_TIMER_EN to build the 32-bit cycle timer with compare flag.
module nanov_periph_hub #(
    parameter int          NUM_GPIO      = 8,
    parameter int          TX_FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR     = 32'h1000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         bus_wdata,
    input  logic                bus_addr_strobe,
    input  logic                bus_write,
    input  logic                bus_data_strobe,
    output logic [31:0]         bus_rdata,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oe,
    output logic                uart_tx_start,
    output logic [7:0]          uart_tx_data,
    input  logic                uart_tx_busy,
    input  logic [7:0]          uart_rx_data,
    input  logic                uart_rx_valid,
    output logic                uart_rx_read,
    output logic                timer_irq
);
    localparam int AW = $clog2(TX_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int S_GPIO = 0, S_OE = 1, S_DATA = 2, S_STAT = 3, S_TMR = 4, S_CMP = 5;

    typedef enum logic {TX_IDLE, TX_HOLD} tx_state_t;

    // Bus protocol: an addr strobe latches a one-hot register select and the
    // write flag; each later data strobe acts on that select until the next
    // addr strobe. No backpressure: every strobe completes in its own cycle.
    logic [5:0]  sel, sel_next;
    logic        wr_flag;
    logic [31:0] wdata_rev;

    always_comb begin
        sel_next = '0;
        if (bus_wdata[31:5] == BASE_ADDR[31:5]) begin
            case (bus_wdata[4:0])
                5'h00:   sel_next[S_GPIO] = 1'b1;
                5'h04:   sel_next[S_OE]   = 1'b1;
                5'h10:   sel_next[S_DATA] = 1'b1;
                5'h14:   sel_next[S_STAT] = 1'b1;
                5'h18:   sel_next[S_TMR]  = 1'b1;
                5'h1C:   sel_next[S_CMP]  = 1'b1;
                default: sel_next = '0;
            endcase
        end
    end

    always_comb begin
        wdata_rev = '0;
        for (int i = 0; i < 32; i++) wdata_rev[i] = bus_wdata[31-i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel     <= '0;
            wr_flag <= 1'b0;
        end else if (bus_addr_strobe) begin
            sel     <= sel_next;
            wr_flag <= bus_write;
        end
    end

    logic do_wr, wr_gpio, wr_oe, wr_data, wr_stat;
    assign do_wr        = bus_data_strobe & wr_flag;
    assign wr_gpio      = do_wr & sel[S_GPIO];
    assign wr_oe        = do_wr & sel[S_OE];
    assign wr_data      = do_wr & sel[S_DATA];
    assign wr_stat      = do_wr & sel[S_STAT];
    assign uart_rx_read = bus_data_strobe & ~wr_flag & sel[S_DATA];

    logic [NUM_GPIO-1:0] sync1, sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_out <= '0;
            gpio_oe  <= '0;
            sync1    <= '0;
            sync2    <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            if (wr_gpio) gpio_out <= wdata_rev[NUM_GPIO-1:0];
            if (wr_oe)   gpio_oe  <= wdata_rev[NUM_GPIO-1:0];
        end
    end

    logic [7:0]    mem [TX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf, full, empty, push, pop;
    tx_state_t     tx_state;

    assign full  = (count == CW'(TX_FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = (tx_state == TX_IDLE) & ~empty & ~uart_tx_busy;
    // A full FIFO still accepts a byte when the drain pops in the same cycle.
    assign push  = wr_data & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TX_FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata_rev[7:0];
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (wr_data & full & ~pop)      ovf <= 1'b1;
            else if (wr_stat & wdata_rev[3]) ovf <= 1'b0;
        end
    end

    // HOLD gives uart_tx one cycle to raise busy before the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state      <= TX_IDLE;
            uart_tx_start <= 1'b0;
            uart_tx_data  <= '0;
        end else begin
            uart_tx_start <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (pop) begin
                        uart_tx_start <= 1'b1;
                        uart_tx_data  <= mem[rd_ptr];
                        tx_state      <= TX_HOLD;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic [31:0] timer_rd, cmp_rd;
`ifdef NANOV_PERIPH_TIMER_EN
    logic [31:0] timer, timer_cmp;
    logic        irq;
    logic        wr_tmr, wr_cmp;
    assign wr_tmr = do_wr & sel[S_TMR];
    assign wr_cmp = do_wr & sel[S_CMP];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            timer_cmp <= '0;
            irq       <= 1'b0;
        end else begin
            timer <= wr_tmr ? wdata_rev : timer + 32'd1;
            if (wr_cmp) timer_cmp <= wdata_rev;
            irq <= wr_cmp ? 1'b0 : (irq | (timer == timer_cmp));
        end
    end
    assign timer_irq = irq;
    assign timer_rd  = timer;
    assign cmp_rd    = timer_cmp;
`else
    assign timer_irq = 1'b0;
    assign timer_rd  = '0;
    assign cmp_rd    = '0;
`endif

    logic [31:0] gpio_rd, oe_rd, stat_rd;
    always_comb begin
        gpio_rd = '0;
        oe_rd   = '0;
        stat_rd = '0;
        gpio_rd[NUM_GPIO-1:0] = sync2;
        oe_rd[NUM_GPIO-1:0]   = gpio_oe;
        stat_rd[0]      = full;
        stat_rd[1]      = uart_rx_valid;
        stat_rd[2]      = empty;
        stat_rd[3]      = ovf;
        stat_rd[8 +: CW] = count;
    end

    always_comb begin
        bus_rdata = '0;
        if (sel[S_GPIO]) bus_rdata = gpio_rd;
        if (sel[S_OE])   bus_rdata = oe_rd;
        if (sel[S_DATA]) bus_rdata = {24'd0, uart_rx_data};
        if (sel[S_STAT]) bus_rdata = stat_rd;
        if (sel[S_TMR])  bus_rdata = timer_rd;
        if (sel[S_CMP])  bus_rdata = cmp_rd;
    end

    logic unused_bits;
    assign unused_bits = ^{wdata_rev, sel};
endmodule

// File: tb/tb_nanov_periph_hub.sv
// Directed bench for nanov_periph_hub; timer checks follow NANOV_PERIPH_TIMER_EN.
module tb_nanov_periph_hub;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic        bus_addr_strobe = 1'b0;
    logic        bus_write = 1'b0;
    logic        bus_data_strobe = 1'b0;
    logic [31:0] bus_rdata;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out, gpio_oe;
    logic        uart_tx_start;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_read;
    logic        timer_irq;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];

    nanov_periph_hub dut (
        .clk(clk), .rst_n(rst_n), .bus_wdata(bus_wdata),
        .bus_addr_strobe(bus_addr_strobe), .bus_write(bus_write),
        .bus_data_strobe(bus_data_strobe), .bus_rdata(bus_rdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe),
        .uart_tx_start(uart_tx_start), .uart_tx_data(uart_tx_data),
        .uart_tx_busy(uart_tx_busy), .uart_rx_data(uart_rx_data),
        .uart_rx_valid(uart_rx_valid), .uart_rx_read(uart_rx_read),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && uart_tx_start) begin
            got_q.push_back(uart_tx_data);
            got_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic addr_ph(input logic [31:0] a, input logic w);
        bus_wdata = a;
        bus_write = w;
        bus_addr_strobe = 1'b1;
        tick(1);
        bus_addr_strobe = 1'b0;
        bus_write = 1'b0;
        bus_wdata = '0;
    endtask

    task automatic data_ph(input logic [31:0] d);
        bus_wdata = d;
        bus_data_strobe = 1'b1;
        tick(1);
        bus_data_strobe = 1'b0;
        bus_wdata = '0;
    endtask

    task automatic reg_wr(input logic [4:0] off, input logic [31:0] v);
        addr_ph(BASE + {27'd0, off}, 1'b1);
        data_ph(rev(v));
    endtask

    task automatic reg_sel(input logic [4:0] off);
        addr_ph(BASE + {27'd0, off}, 1'b0);
    endtask

    task automatic chk_sent(input string tag);
        chk({tag, "_n"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(tag, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    endtask

    initial begin
        #3;
        chk("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
        chk("rst_gpio_oe", {24'd0, gpio_oe}, 32'd0);
        chk("rst_tx_start", {31'd0, uart_tx_start}, 32'd0);
        chk("rst_rx_read", {31'd0, uart_rx_read}, 32'd0);
        chk("rst_irq", {31'd0, timer_irq}, 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(1);

        reg_sel(5'h04);
        chk("oe_rd_rst", bus_rdata, 32'd0);
        addr_ph(BASE + 32'h04, 1'b1);
        data_ph(32'hA500_0000);
        chk("oe_out", {24'd0, gpio_oe}, 32'hA5);
        reg_sel(5'h04);
        chk("oe_rd", bus_rdata, 32'h0000_00A5);
        reg_wr(5'h00, 32'h5A);
        chk("gpio_out", {24'd0, gpio_out}, 32'h5A);

        reg_sel(5'h00);
        gpio_in = 8'h3C;
        tick(1);
        chk("gpio_sync_1", bus_rdata, 32'h0);
        tick(1);
        chk("gpio_sync_2", bus_rdata, 32'h3C);
        addr_ph(32'h1000_0020, 1'b0);
        chk("addr_outside", bus_rdata, 32'h0);
        reg_sel(5'h00);
        addr_ph(32'h1000_0001, 1'b0);
        chk("addr_unaligned", bus_rdata, 32'h0);

        got_q.delete(); got_cyc.delete(); exp_q.delete();
        reg_wr(5'h10, 32'h41);
        reg_wr(5'h10, 32'h42);
        tick(6);
        exp_q = '{8'h41, 8'h42};
        chk_sent("tx_b2b");
        if (got_cyc.size() == 2)
            chk("tx_gap_ge2", {31'd0, (got_cyc[1] - got_cyc[0]) >= 2}, 32'd1);

        got_q.delete(); got_cyc.delete(); exp_q.delete();
        reg_wr(5'h10, 32'h43);
        tick(1);
        uart_tx_busy = 1'b1;
        reg_wr(5'h10, 32'h44);
        tick(10);
        exp_q = '{8'h43};
        chk_sent("tx_stall");
        uart_tx_busy = 1'b0;
        tick(4);
        exp_q = '{8'h43, 8'h44};
        chk_sent("tx_release");

        got_q.delete(); got_cyc.delete(); exp_q.delete();
        uart_tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) reg_wr(5'h10, 32'h10 + i);
        reg_sel(5'h14);
        chk("stat_full_ovf", bus_rdata, 32'h0000_0409);
        reg_wr(5'h14, 32'h8);
        reg_sel(5'h14);
        chk("stat_ovf_clr", bus_rdata, 32'h0000_0401);
        uart_tx_busy = 1'b0;
        tick(12);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        chk_sent("tx_drain");
        reg_sel(5'h14);
        chk("stat_empty", bus_rdata, 32'h0000_0004);

        uart_rx_valid = 1'b1;
        uart_rx_data = 8'h55;
        tick(1);
        chk("stat_rxv", bus_rdata, 32'h0000_0006);
        reg_sel(5'h10);
        chk("rx_data", bus_rdata, 32'h55);
        chk("rx_read_idle", {31'd0, uart_rx_read}, 32'd0);
        bus_data_strobe = 1'b1;
        #1;
        chk("rx_read_pulse", {31'd0, uart_rx_read}, 32'd1);
        @(posedge clk);
        #1;
        bus_data_strobe = 1'b0;
        #1;
        chk("rx_read_end", {31'd0, uart_rx_read}, 32'd0);
        uart_rx_valid = 1'b0;
        tick(1);

`ifdef NANOV_PERIPH_TIMER_EN
        reg_wr(5'h1C, 32'h1);
        chk("irq_clr_cmp", {31'd0, timer_irq}, 32'd0);
        reg_wr(5'h18, 32'hFFFF_FFFE);
        chk("tmr_load", bus_rdata, 32'hFFFF_FFFE);
        chk("irq_l0", {31'd0, timer_irq}, 32'd0);
        tick(2);
        chk("tmr_wrap", bus_rdata, 32'h0);
        chk("irq_l2", {31'd0, timer_irq}, 32'd0);
        tick(1);
        chk("irq_l3", {31'd0, timer_irq}, 32'd0);
        tick(1);
        chk("irq_l4", {31'd0, timer_irq}, 32'd1);
        tick(3);
        chk("irq_sticky", {31'd0, timer_irq}, 32'd1);
        reg_wr(5'h1C, 32'h5);
        chk("irq_cmp_wr", {31'd0, timer_irq}, 32'd0);
        reg_sel(5'h1C);
        chk("cmp_rd", bus_rdata, 32'h5);
`else
        reg_wr(5'h18, 32'h1234);
        reg_sel(5'h18);
        chk("tmr_off_rd", bus_rdata, 32'h0);
        reg_wr(5'h1C, 32'h0);
        tick(5);
        chk("irq_off", {31'd0, timer_irq}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
